// File: rtl/vanilla_scoreboard_clear_responder.sv
// vanilla_scoreboard_clear_responder
//   Bench-side responder for the vanilla core scoreboard. Accepts set events
//   (long-latency writes by register id), holds each one for its latency, then
//   returns int/float scoreboard clears toward the core and tracker.
//   Optional build macro: VANILLA_SB_RESPONDER_JITTER_EN adds an LFSR-driven
//   0..3 cycle jitter to each accepted latency so clears come back reordered.
//
// Handshake: an issue is accepted in any cycle where issue_v_i and
// issue_ready_o are both high. issue_ready_o depends only on registered state,
// so a clear leaving in the same cycle never makes room for that cycle's issue.
// A clear strobe fires only when the matching *_wb_ready_i is high; otherwise
// the candidate stays pending and is offered again the next cycle.
module vanilla_scoreboard_clear_responder #(
  parameter int els_p            = 8,
  parameter int reg_addr_width_p = 5,
  parameter int latency_width_p  = 8,
  parameter int age_width_p      = 4
) (
  input  logic                          clk_i,
  input  logic                          reset_i,
  input  logic                          issue_v_i,
  input  logic                          issue_float_i,
  input  logic [reg_addr_width_p-1:0]   issue_rd_i,
  input  logic [latency_width_p-1:0]    issue_latency_i,
  output logic                          issue_ready_o,
  input  logic                          int_wb_ready_i,
  input  logic                          float_wb_ready_i,
  output logic                          int_sb_clear_o,
  output logic [reg_addr_width_p-1:0]   int_sb_clear_id_o,
  output logic                          float_sb_clear_o,
  output logic [reg_addr_width_p-1:0]   float_sb_clear_id_o,
  output logic [$clog2(els_p+1)-1:0]    pending_count_o,
  output logic                          overflow_o
);

  localparam int idx_w_lp = (els_p > 1) ? $clog2(els_p) : 1;
  localparam int cnt_w_lp = $clog2(els_p+1);
  localparam logic [age_width_p-1:0]     age_max_lp = '1;
  localparam logic [age_width_p-1:0]     age_one_lp = 1;
  localparam logic [latency_width_p-1:0] lat_one_lp = 1;

  // Pending table
  logic [els_p-1:0]            valid_r;
  logic [els_p-1:0]            float_r;
  logic [reg_addr_width_p-1:0] rd_r    [els_p];
  logic [latency_width_p-1:0]  count_r [els_p];
  logic [age_width_p-1:0]      age_r   [els_p];
  logic                        overflow_r;

  logic                        free_found;
  logic [idx_w_lp-1:0]         free_idx;
  logic                        accept;
  logic [latency_width_p-1:0]  issue_count;

  logic                        int_found, float_found;
  logic [idx_w_lp-1:0]         int_idx, float_idx;
  logic [age_width_p-1:0]      int_age, float_age;
  logic [els_p-1:0]            clr_mask;
  logic [cnt_w_lp-1:0]         pend_cnt;

`ifdef VANILLA_SB_RESPONDER_JITTER_EN
  logic [7:0]                  lfsr_r;
  logic [latency_width_p:0]    jitter_sum;

  // Free-running Fibonacci LFSR, taps 8,6,5,4
  always_ff @(posedge clk_i) begin
    if (reset_i) lfsr_r <= 8'hA5;
    else         lfsr_r <= {lfsr_r[6:0], lfsr_r[7] ^ lfsr_r[5] ^ lfsr_r[4] ^ lfsr_r[3]};
  end

  // Latency plus 0..3 cycles of jitter, saturating at the counter maximum
  always_comb begin
    jitter_sum  = {1'b0, issue_latency_i} + (latency_width_p+1)'(lfsr_r[1:0]);
    issue_count = jitter_sum[latency_width_p] ? '1 : jitter_sum[latency_width_p-1:0];
  end
`else
  assign issue_count = issue_latency_i;
`endif

  // Lowest-index free entry; any free entry means we can accept
  always_comb begin
    free_found = 1'b0;
    free_idx   = '0;
    for (int i = 0; i < els_p; i++) begin
      if (!valid_r[i] && !free_found) begin
        free_found = 1'b1;
        free_idx   = idx_w_lp'(i);
      end
    end
  end

  assign issue_ready_o = free_found;
  assign accept        = issue_v_i & issue_ready_o;

  // Per-side oldest eligible entry; strict compare keeps the lowest index on ties
  always_comb begin
    int_found   = 1'b0;
    int_idx     = '0;
    int_age     = '0;
    float_found = 1'b0;
    float_idx   = '0;
    float_age   = '0;
    for (int i = 0; i < els_p; i++) begin
      if (valid_r[i] && (count_r[i] == '0)) begin
        if (float_r[i]) begin
          if (!float_found || (age_r[i] > float_age)) begin
            float_found = 1'b1;
            float_idx   = idx_w_lp'(i);
            float_age   = age_r[i];
          end
        end else begin
          if (!int_found || (age_r[i] > int_age)) begin
            int_found = 1'b1;
            int_idx   = idx_w_lp'(i);
            int_age   = age_r[i];
          end
        end
      end
    end
  end

  // Clear strobes gated by writeback availability; nothing leaves during reset
  always_comb begin
    int_sb_clear_o      = int_found & int_wb_ready_i & ~reset_i;
    float_sb_clear_o    = float_found & float_wb_ready_i & ~reset_i;
    int_sb_clear_id_o   = int_sb_clear_o   ? rd_r[int_idx]   : '0;
    float_sb_clear_id_o = float_sb_clear_o ? rd_r[float_idx] : '0;
    clr_mask            = '0;
    for (int i = 0; i < els_p; i++) begin
      if ((int_sb_clear_o && (int_idx == idx_w_lp'(i))) ||
          (float_sb_clear_o && (float_idx == idx_w_lp'(i))))
        clr_mask[i] = 1'b1;
    end
  end

  // Occupancy of the registered table
  always_comb begin
    pend_cnt = '0;
    for (int i = 0; i < els_p; i++) pend_cnt = pend_cnt + cnt_w_lp'(valid_r[i]);
  end

  assign pending_count_o = pend_cnt;
  assign overflow_o      = overflow_r;

  // Table update: retire cleared entries, count down and age the rest, write accepts
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      valid_r    <= '0;
      float_r    <= '0;
      overflow_r <= 1'b0;
      for (int i = 0; i < els_p; i++) begin
        rd_r[i]    <= '0;
        count_r[i] <= '0;
        age_r[i]   <= '0;
      end
    end else begin
      overflow_r <= overflow_r | (issue_v_i & ~issue_ready_o);
      for (int i = 0; i < els_p; i++) begin
        if (clr_mask[i]) begin
          valid_r[i] <= 1'b0;
        end else if (valid_r[i]) begin
          if (count_r[i] != '0) count_r[i] <= count_r[i] - lat_one_lp;
          if (age_r[i] != age_max_lp) age_r[i] <= age_r[i] + age_one_lp;
        end
        if (accept && (free_idx == idx_w_lp'(i))) begin
          valid_r[i] <= 1'b1;
          float_r[i] <= issue_float_i;
          rd_r[i]    <= issue_rd_i;
          count_r[i] <= issue_count;
          age_r[i]   <= '0;
        end
      end
    end
  end

endmodule
